icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 112 +++++++++++
 tb/tb_icache.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Zero-latency hits, refill bypass and flush-safe draining of outstanding fetches.
module icache #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_in,
  input  logic        inst_enable_in,
  input  logic [31:0] inst_addr_in,
  output logic        inst_enable_out,
  output logic [31:0] inst_value_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_data_in
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [29:0]       addr_q, addr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic                  hit, fill, unused_addr_bits;

  assign rd_idx = inst_addr_in[INDEX_BITS+1:2];
  assign rd_tag = inst_addr_in[31:INDEX_BITS+2];
  assign wr_idx = addr_q[INDEX_BITS-1:0];
  assign wr_tag = addr_q[29:INDEX_BITS];
  assign unused_addr_bits = ^inst_addr_in[1:0];

  assign hit = (state_q == IDLE) && inst_enable_in && !flush_in &&
               valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  // Any returning word is written, even after a flush, so the line is not lost.
  assign fill = (state_q != IDLE) && mem_done_in;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    valid_d         = valid_q;
    inst_enable_out = 1'b0;
    inst_value_out  = 32'h0;
    if (fill) begin
      valid_d[wr_idx] = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          inst_enable_out = 1'b1;
          inst_value_out  = data_mem[rd_idx];
        end else if (inst_enable_in && !flush_in) begin
          addr_d  = inst_addr_in[31:2];
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mem_done_in) begin
          state_d = IDLE;
          if (!flush_in && inst_enable_in &&
              inst_addr_in[31:2] == addr_q) begin
            inst_enable_out = 1'b1;
            inst_value_out  = mem_data_in;
          end
        end else if (flush_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_out  = (state_q != IDLE);
  assign mem_addr_out = mem_req_out ? {addr_q, 2'b00} : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict,
// flush mid-miss, flush+done, and reset mid-fetch.
module tb_icache;

  logic        clk;
  logic        rst_n;
  logic        flush_in;
  logic        inst_enable_in;
  logic [31:0] inst_addr_in;
  logic        inst_enable_out;
  logic [31:0] inst_value_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;

  int n_chk;
  int n_pass;

  icache #(.INDEX_BITS(7)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_in       (flush_in),
    .inst_enable_in (inst_enable_in),
    .inst_addr_in   (inst_addr_in),
    .inst_enable_out(inst_enable_out),
    .inst_value_out (inst_value_out),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_done_in    (mem_done_in),
    .mem_data_in    (mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic en, input logic [31:0] a,
                     input logic fl, input logic dn,
                     input logic [31:0] d);
    inst_enable_in = en;
    inst_addr_in   = a;
    flush_in       = fl;
    mem_done_in    = dn;
    mem_data_in    = d;
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    chk("rst_en", inst_enable_out, 0);
    chk("rst_val", inst_value_out, 0);
    chk("rst_req", mem_req_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // cold miss on 0x4
    drv(1, 32'h4, 0, 0, 0);
    chk("cold_miss_en", inst_enable_out, 0);
    chk("cold_idle_req", mem_req_out, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h4, 0, 0, 0);
      chk("cold_req", mem_req_out, 1);
      chk("cold_addr", mem_addr_out, 32'h4);
      chk("cold_wait_en", inst_enable_out, 0);
      tick();
    end
    drv(1, 32'h4, 0, 1, 32'h00500093);
    chk("cold_byp_en", inst_enable_out, 1);
    chk("cold_byp_val", inst_value_out, 32'h00500093);
    tick();

    // hit
    drv(1, 32'h4, 0, 0, 0);
    chk("hit_en", inst_enable_out, 1);
    chk("hit_val", inst_value_out, 32'h00500093);
    chk("hit_req", mem_req_out, 0);
    tick();

    // flush blocks a hit in IDLE
    drv(1, 32'h4, 1, 0, 0);
    chk("flush_hit_en", inst_enable_out, 0);
    chk("flush_hit_val", inst_value_out, 0);
    tick();

    // conflict 0x204 evicts 0x4
    drv(1, 32'h204, 0, 0, 0);
    chk("conf_miss_en", inst_enable_out, 0);
    tick();
    drv(1, 32'h204, 0, 0, 0);
    chk("conf_addr", mem_addr_out, 32'h204);
    tick();
    drv(1, 32'h204, 0, 1, 32'h11111111);
    chk("conf_byp_val", inst_value_out, 32'h11111111);
    tick();
    drv(1, 32'h4, 0, 0, 0);
    chk("evict_miss_en", inst_enable_out, 0);
    tick();
    drv(1, 32'h4, 0, 0, 0);
    chk("evict_req", mem_req_out, 1);
    chk("evict_addr", mem_addr_out, 32'h4);
    tick();
    drv(0, 32'h4, 0, 1, 32'h00500093);
    chk("byp_no_en", inst_enable_out, 0);
    tick();
    drv(1, 32'h204, 0, 0, 0);
    chk("conf_gone_en", inst_enable_out, 0);
    drv(0, 0, 0, 0, 0);
    chk("noreq_idle", mem_req_out, 0);
    tick();

    // flush mid-miss on 0x100
    drv(1, 32'h100, 0, 0, 0);
    tick();
    drv(1, 32'h100, 0, 0, 0);
    chk("fm_req1", mem_req_out, 1);
    tick();
    drv(1, 32'h100, 1, 0, 0);
    chk("fm_flush_en", inst_enable_out, 0);
    tick();
    drv(1, 32'h100, 0, 0, 0);
    chk("drain_req", mem_req_out, 1);
    chk("drain_addr", mem_addr_out, 32'h100);
    tick();
    drv(1, 32'h100, 0, 1, 32'h22222222);
    chk("drain_done_en", inst_enable_out, 0);
    chk("drain_done_val", inst_value_out, 0);
    tick();
    drv(1, 32'h100, 0, 0, 0);
    chk("drain_hit_en", inst_enable_out, 1);
    chk("drain_hit_val", inst_value_out, 32'h22222222);
    chk("drain_idle_req", mem_req_out, 0);
    tick();

    // flush and done together on 0x300
    drv(1, 32'h300, 0, 0, 0);
    tick();
    drv(1, 32'h300, 1, 1, 32'h33333333);
    chk("fd_en", inst_enable_out, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("fd_idle_req", mem_req_out, 0);
    chk("fd_idle_addr", mem_addr_out, 0);
    drv(1, 32'h300, 0, 0, 0);
    chk("fd_hit_en", inst_enable_out, 1);
    chk("fd_hit_val", inst_value_out, 32'h33333333);
    tick();

    // reset mid-fetch on 0x508
    drv(1, 32'h508, 0, 0, 0);
    tick();
    drv(1, 32'h508, 0, 0, 0);
    chk("rf_req", mem_req_out, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_req_async", mem_req_out, 0);
    chk("rf_addr_async", mem_addr_out, 0);
    tick();
    rst_n = 1'b1;
    drv(0, 32'h508, 0, 1, 32'h44444444);
    chk("stray_done_en", inst_enable_out, 0);
    chk("stray_done_req", mem_req_out, 0);
    tick();
    drv(1, 32'h4, 0, 0, 0);
    chk("post_rst_miss", inst_enable_out, 0);
    tick();
    drv(1, 32'h4, 0, 0, 0);
    chk("post_rst_req", mem_req_out, 1);
    chk("post_rst_addr", mem_addr_out, 32'h4);
    tick();
    drv(1, 32'h4, 0, 1, 32'h55555555);
    chk("post_rst_byp", inst_value_out, 32'h55555555);
    tick();
    drv(0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
